// File: rtl/bnn_layer_seq.sv
// Layer sequencer for a binarised NN core: bias load, per-group load/accumulate, binarise.
// Optional 2x2 pooling (four windows per layer) is built only when BNN_SEQ_POOL_EN is defined.
module bnn_layer_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cfg_groups,
    input  logic       cfg_pool,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       bias_wr,
    output logic       acc_clr,
    output logic [3:0] bpug_sel,
    output logic       bpug_load,
    output logic       psum_add,
    output logic       bin_wr,
    output logic       pool_en,
    output logic [1:0] pool_idx
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_CLR  = 3'd2,
        S_LOAD = 3'd3,
        S_ACC  = 3'd4,
        S_BIN  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] g_q, g_d;
    logic [3:0] groups_q, groups_d;
    logic       bias_cnt_q, bias_cnt_d;

`ifdef BNN_SEQ_POOL_EN
    logic       pool_q, pool_d;
    logic [1:0] w_q, w_d;
`else
    logic       unused_cfg_pool;
    assign unused_cfg_pool = cfg_pool;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            g_q        <= 4'd0;
            groups_q   <= 4'd0;
            bias_cnt_q <= 1'b0;
`ifdef BNN_SEQ_POOL_EN
            pool_q     <= 1'b0;
            w_q        <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            groups_q   <= groups_d;
            bias_cnt_q <= bias_cnt_d;
`ifdef BNN_SEQ_POOL_EN
            pool_q     <= pool_d;
            w_q        <= w_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        groups_d   = groups_q;
        bias_cnt_d = bias_cnt_q;
`ifdef BNN_SEQ_POOL_EN
        pool_d     = pool_q;
        w_d        = w_q;
`endif
        in_ready   = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        bias_wr    = 1'b0;
        acc_clr    = 1'b0;
        bpug_sel   = 4'd0;
        bpug_load  = 1'b0;
        psum_add   = 1'b0;
        bin_wr     = 1'b0;
        pool_en    = 1'b0;
        pool_idx   = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    groups_d   = cfg_groups;
                    g_d        = 4'd0;
                    bias_cnt_d = 1'b0;
`ifdef BNN_SEQ_POOL_EN
                    pool_d     = cfg_pool;
                    w_d        = 2'd0;
`endif
                    state_d    = S_BIAS;
                end
            end
            // Two bias words per layer; bias_cnt_q marks the first one seen.
            S_BIAS: begin
                in_ready = 1'b1;
                bias_wr  = in_valid;
                if (in_valid) begin
                    if (bias_cnt_q) state_d = S_CLR;
                    else            bias_cnt_d = 1'b1;
                end
            end
            S_CLR: begin
                acc_clr = 1'b1;
                g_d     = 4'd0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                bpug_sel  = g_q;
                bpug_load = in_valid;
                if (in_valid) state_d = S_ACC;
            end
            // g stops at groups_q, so it can never wrap even for 16 groups.
            S_ACC: begin
                psum_add = 1'b1;
                bpug_sel = g_q;
                if (g_q == groups_q) begin
                    state_d = S_BIN;
                end else begin
                    g_d     = g_q + 4'd1;
                    state_d = S_LOAD;
                end
            end
            S_BIN: begin
                bin_wr  = 1'b1;
                state_d = S_DONE;
`ifdef BNN_SEQ_POOL_EN
                pool_en  = pool_q;
                pool_idx = w_q;
                // Next pooling window reuses the bias already in the core.
                if (pool_q && (w_q != 2'd3)) begin
                    w_d     = w_q + 2'd1;
                    state_d = S_CLR;
                end
`endif
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
